noc_traffic_gen: RTL and testbench
==================================

// Module: noc_traffic_gen
// PURPOSE
//  Parametrised traffic generator driving one input port of noc_router in NoC benches/BIST.
//  Emits flits {seq, src_id, dst_id, 1'b1} under FIFO back-pressure (full/almost_full).
//  Supports fixed, round-robin and pseudo-random destinations, inter-flit gap and packet limit.
//  Reports sent and stall counts.
// PARAMETERS
//  WIDTH      12        flit width; SEQ_W = WIDTH-2*ADDR_W-1, must be >= 1
//  ADDR_W     2         node address width; node count = 2**ADDR_W
//  LFSR_SEED  16'hACE1  random-mode LFSR reset value, must be non-zero
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous, active-high
//  full         in   1       destination FIFO full
//  almost_full  in   1       destination FIFO almost full
//  enable       in   1       1 = generate; 0 = hold (in DONE: restart)
//  mode         in   2       00 fixed, 01 round-robin, 10 random, 11 = fixed
//  src_id       in   ADDR_W  own node id placed in flit
//  dst_fixed    in   ADDR_W  destination for fixed mode
//  gap          in   8       idle cycles inserted after each flit
//  pkt_limit    in   16      flits to send; 0 = unlimited
//  data_out     out  WIDTH   flit; valid only while write=1
//  write        out  1       one-cycle write strobe per flit
//  sent_count   out  16      flits issued, saturates at 16'hFFFF
//  stall_count  out  16      enabled cycles blocked by back-pressure, saturating
//  done         out  1       pkt_limit reached
// BEHAVIOUR
//  Reset (sync, first clk edge with reset=1): data_out=0, write=0, sent_count=0,
//   stall_count=0, done=0, seq=0, rr_ptr=0, lfsr=LFSR_SEED, state=RUN. Overrides everything, incl. mid-GAP.
//  blocked = (write & almost_full) | (~write & full).
//  limit_hit = (pkt_limit!=0) & (sent_count>=pkt_limit), evaluated live.
//  States RUN, GAP, DONE. Outputs registered; flit appears the edge after the issue decision.
//  RUN:
//   - Issue if enable & ~blocked & ~limit_hit.
//     write<=1, data_out<=flit, seq++ (wraps at 2**SEQ_W), sent_count++.
//     Then go to DONE if sent_count+1==pkt_limit (limit!=0), else GAP if gap!=0, else stay in RUN.
//   - Otherwise write<=0; stall_count++ iff enable & blocked.
//   - limit_hit with no issue (limit lowered live) -> DONE.
//  GAP: write<=0; gap counter loaded with gap at issue, decrements each cycle, -> RUN when it reaches 0.
//   Exactly gap idle cycles follow each flit. Counts regardless of enable; stalls not counted.
//  DONE: write<=0, done<=1 (asserted the cycle after the last write). Stays until enable=0.
//   Then: sent_count<=0, done<=0, -> RUN; seq and stall_count are kept.
//  Destination is sampled at issue; mode, dst_fixed and gap changes take effect at the next issue.
//   fixed: dst_fixed.
//   rr: dst=rr_ptr; then rr_ptr advances mod 2**ADDR_W, skipping src_id (never sends to self).
//    If rr_ptr==src_id at issue, it is skipped first.
//   random: dst=lfsr[ADDR_W-1:0]; self allowed.
//    lfsr is a 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11, advanced only on issue.
//  gap=0 with no back-pressure: one flit every cycle.
// TESTING
//  WIDTH=12, ADDR_W=2, src_id=2 in all scenarios.
//  1 Free run: mode 00, dst_fixed=3, gap=0, limit=0, full=0, enable=1 after reset
//    -> write=1 every cycle; data_out 12'h017, 12'h037, 12'h057, ...
//  2 Back-pressure: almost_full=1 while write=1 -> write=0 next cycle; hold full=1 for 5 cycles
//    -> stall_count +5; release -> next flit carries the next seq with no skip.
//  3 Gap: gap=3 -> write pattern 1,0,0,0 repeating; sent_count increments every 4 cycles.
//  4 Limit: pkt_limit=5 -> exactly 5 writes, done=1 one cycle after the 5th;
//    enable=0 for 1 cycle -> done=0, sent_count=0; enable=1 -> traffic resumes.
//  5 Round-robin: mode 01 -> dst field sequence 0,1,3,0,1,3; never 2.
//  6 Wrap/reset: after 128 flits seq returns to 0; reset=1 mid-GAP
//    -> next edge write=0, data_out=0, counters=0.

Source files
------------

// File: rtl/noc_traffic_gen.sv
// rtl/noc_traffic_gen.sv - flit traffic generator for one noc_router input port
module noc_traffic_gen #(
    parameter int          WIDTH     = 12,
    parameter int          ADDR_W    = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              full,
    input  logic              almost_full,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_id,
    input  logic [ADDR_W-1:0] dst_fixed,
    input  logic [7:0]        gap,
    input  logic [15:0]       pkt_limit,
    output logic [WIDTH-1:0]  data_out,
    output logic              write,
    output logic [15:0]       sent_count,
    output logic [15:0]       stall_count,
    output logic              done
);

    localparam int SEQ_W = WIDTH - 2*ADDR_W - 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [SEQ_W-1:0]  ONE_S = 1;

    typedef enum logic [1:0] {S_RUN, S_GAP, S_DONE} state_t;

    state_t            state;
    logic [SEQ_W-1:0]  seq;
    logic [ADDR_W-1:0] rr_ptr;
    logic [15:0]       lfsr;
    logic [7:0]        gap_cnt;

    logic              blocked;
    logic              limit_hit;
    logic              issue;
    logic              last_flit;
    logic [ADDR_W-1:0] rr_dst;
    logic [ADDR_W-1:0] rr_step;
    logic [ADDR_W-1:0] rr_next;
    logic [ADDR_W-1:0] dst;
    logic [15:0]       lfsr_next;
    logic [WIDTH-1:0]  flit;
    logic [15:0]       sent_inc;
    logic [15:0]       stall_inc;

    // The FIFO sees our previous write only after this edge, so back-pressure
    // uses almost_full when a write is already in flight.
    always_comb begin
        blocked   = write ? almost_full : full;
        limit_hit = (pkt_limit != 16'd0) && (sent_count >= pkt_limit);
        issue     = enable && !blocked && !limit_hit;
        last_flit = (pkt_limit != 16'd0) && (({1'b0, sent_count} + 17'd1) == {1'b0, pkt_limit});

        rr_dst  = (rr_ptr == src_id) ? rr_ptr + ONE_A : rr_ptr;
        rr_step = rr_dst + ONE_A;
        rr_next = (rr_step == src_id) ? rr_step + ONE_A : rr_step;

        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

        case (mode)
            2'b01:   dst = rr_dst;
            2'b10:   dst = lfsr[ADDR_W-1:0];
            default: dst = dst_fixed;
        endcase

        flit      = {seq, src_id, dst, 1'b1};
        sent_inc  = (sent_count == 16'hFFFF) ? sent_count : sent_count + 16'd1;
        stall_inc = (stall_count == 16'hFFFF) ? stall_count : stall_count + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            data_out    <= '0;
            write       <= 1'b0;
            sent_count  <= 16'd0;
            stall_count <= 16'd0;
            done        <= 1'b0;
            seq         <= '0;
            rr_ptr      <= '0;
            lfsr        <= LFSR_SEED;
            gap_cnt     <= 8'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (issue) begin
                        write      <= 1'b1;
                        data_out   <= flit;
                        seq        <= seq + ONE_S;
                        sent_count <= sent_inc;
                        if (mode == 2'b01)
                            rr_ptr <= rr_next;
                        if (mode == 2'b10)
                            lfsr <= lfsr_next;
                        if (last_flit) begin
                            state <= S_DONE;
                        end else if (gap != 8'd0) begin
                            gap_cnt <= gap;
                            state   <= S_GAP;
                        end
                    end else begin
                        write <= 1'b0;
                        if (enable && blocked)
                            stall_count <= stall_inc;
                        if (limit_hit)
                            state <= S_DONE;
                    end
                end
                S_GAP: begin
                    write   <= 1'b0;
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt <= 8'd1)
                        state <= S_RUN;
                end
                S_DONE: begin
                    write <= 1'b0;
                    if (!enable) begin
                        sent_count <= 16'd0;
                        done       <= 1'b0;
                        state      <= S_RUN;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb/tb_noc_traffic_gen.sv - self-checking bench for noc_traffic_gen
module tb_noc_traffic_gen;

    localparam int SRC = 2;

    logic        clk;
    logic        reset;
    logic        full;
    logic        almost_full;
    logic        enable;
    logic [1:0]  mode;
    logic [1:0]  src_id;
    logic [1:0]  dst_fixed;
    logic [7:0]  gap;
    logic [15:0] pkt_limit;
    logic [11:0] data_out;
    logic        write;
    logic [15:0] sent_count;
    logic [15:0] stall_count;
    logic        done;

    int checks;
    int errors;

    // Reference model state
    int          m_seq;
    int          m_rr;
    logic [15:0] m_lfsr;
    int          m_sent;
    int          m_stall;
    logic        m_wr;

    noc_traffic_gen #(.WIDTH(12), .ADDR_W(2), .LFSR_SEED(16'hACE1)) dut (
        .clk        (clk),
        .reset      (reset),
        .full       (full),
        .almost_full(almost_full),
        .enable     (enable),
        .mode       (mode),
        .src_id     (src_id),
        .dst_fixed  (dst_fixed),
        .gap        (gap),
        .pkt_limit  (pkt_limit),
        .data_out   (data_out),
        .write      (write),
        .sent_count (sent_count),
        .stall_count(stall_count),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] mk_flit(input int s, input int d);
        return {7'(s), 2'(SRC), 2'(d), 1'b1};
    endfunction

    task automatic model_reset();
        m_seq   = 0;
        m_rr    = 0;
        m_lfsr  = 16'hACE1;
        m_sent  = 0;
        m_stall = 0;
        m_wr    = 1'b0;
    endtask

    task automatic model_issue(input int md, input int df, output logic [11:0] f);
        int d;
        if (md == 1) begin
            d = m_rr;
            if (d == SRC) d = (d + 1) % 4;
            m_rr = (d + 1) % 4;
            if (m_rr == SRC) m_rr = (m_rr + 1) % 4;
        end else if (md == 2) begin
            d = int'(m_lfsr[1:0]);
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else           m_lfsr = m_lfsr >> 1;
        end else begin
            d = df;
        end
        f      = mk_flit(m_seq, d);
        m_seq  = (m_seq + 1) % 128;
        m_sent = m_sent + 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (write !== 1'b0 || data_out !== 12'h000 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs write=%b data=%h done=%b exp 0/000/0", write, data_out, done);
        end
        checks++;
        if (sent_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts sent=%0d stall=%0d exp 0/0", sent_count, stall_count);
        end
    endtask

    task automatic test_free_run();
        logic [11:0] f;
        mode = 2'b00; dst_fixed = 2'd3; gap = 8'd0; pkt_limit = 16'd0;
        full = 1'b0; almost_full = 1'b0; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            model_issue(0, 3, f);
            step();
            m_wr = 1'b1;
            checks++;
            if (write !== 1'b1 || data_out !== f) begin
                errors++;
                $display("FAIL free_run cyc %0d write=%b data=%h exp 1/%h", i, write, data_out, f);
            end
            if (i == 0) begin
                checks++;
                if (data_out !== 12'h017) begin
                    errors++;
                    $display("FAIL free_run_first data=%h exp 017", data_out);
                end
            end
        end
        checks++;
        if (sent_count !== 16'(m_sent)) begin
            errors++;
            $display("FAIL free_run_sent got %0d exp %0d", sent_count, m_sent);
        end
    endtask

    task automatic test_back_pressure();
        logic [11:0] f;
        int base;
        almost_full = 1'b1;
        step();
        m_stall++;
        m_wr = 1'b0;
        checks++;
        if (write !== 1'b0) begin
            errors++;
            $display("FAIL bp_almost_full write=%b exp 0", write);
        end
        almost_full = 1'b0;
        full = 1'b1;
        base = int'(stall_count);
        for (int i = 0; i < 5; i++) begin
            step();
            m_stall++;
            checks++;
            if (write !== 1'b0) begin
                errors++;
                $display("FAIL bp_full cyc %0d write=%b exp 0", i, write);
            end
        end
        checks++;
        if (int'(stall_count) - base != 5) begin
            errors++;
            $display("FAIL bp_stall_delta got %0d exp 5", int'(stall_count) - base);
        end
        full = 1'b0;
        model_issue(0, 3, f);
        step();
        m_wr = 1'b1;
        checks++;
        if (write !== 1'b1 || data_out !== f) begin
            errors++;
            $display("FAIL bp_release write=%b data=%h exp 1/%h", write, data_out, f);
        end
        checks++;
        if (stall_count !== 16'(m_stall)) begin
            errors++;
            $display("FAIL bp_stall_total got %0d exp %0d", stall_count, m_stall);
        end
    endtask

    task automatic test_random_traffic();
        logic [11:0] f;
        logic        en, fl, af, blk, iss;
        int          md, df;
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 3) == 0);
            af = ($urandom_range(0, 2) == 0);
            md = int'($urandom_range(0, 3));
            df = int'($urandom_range(0, 3));
            enable = en; full = fl; almost_full = af;
            mode = 2'(md); dst_fixed = 2'(df);
            blk = m_wr ? af : fl;
            iss = en && !blk;
            if (en && blk) m_stall++;
            f = 12'h000;
            if (iss) model_issue(md, df, f);
            step();
            m_wr = iss;
            checks++;
            if (write !== iss || (iss && data_out !== f)) begin
                errors++;
                $display("FAIL random cyc %0d write=%b data=%h exp %b/%h", i, write, data_out, iss, f);
            end
        end
        checks++;
        if (stall_count !== 16'(m_stall) || sent_count !== 16'(m_sent)) begin
            errors++;
            $display("FAIL random_counts stall=%0d sent=%0d exp %0d/%0d",
                     stall_count, sent_count, m_stall, m_sent);
        end
        enable = 1'b1; full = 1'b0; almost_full = 1'b0; mode = 2'b00; dst_fixed = 2'd3;
    endtask

    task automatic test_gap();
        logic [11:0] f;
        logic        exp_wr;
        int          base;
        gap = 8'd3;
        base = int'(sent_count);
        for (int i = 0; i < 16; i++) begin
            exp_wr = (i % 4 == 0);
            if (exp_wr) model_issue(0, 3, f);
            step();
            m_wr = exp_wr;
            checks++;
            if (write !== exp_wr || (exp_wr && data_out !== f)) begin
                errors++;
                $display("FAIL gap cyc %0d write=%b data=%h exp %b/%h", i, write, data_out, exp_wr, f);
            end
        end
        checks++;
        if (int'(sent_count) - base != 4) begin
            errors++;
            $display("FAIL gap_sent_delta got %0d exp 4", int'(sent_count) - base);
        end
        gap = 8'd0;
    endtask

    task automatic test_limit();
        logic [11:0] f;
        logic        exp_wr, exp_done;
        do_reset();
        mode = 2'b00; dst_fixed = 2'd3; gap = 8'd0; pkt_limit = 16'd5; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_wr   = (i < 5);
            exp_done = (i >= 5);
            if (exp_wr) model_issue(0, 3, f);
            step();
            checks++;
            if (write !== exp_wr || done !== exp_done || (exp_wr && data_out !== f)) begin
                errors++;
                $display("FAIL limit cyc %0d write=%b done=%b data=%h exp %b/%b/%h",
                         i, write, done, data_out, exp_wr, exp_done, f);
            end
        end
        checks++;
        if (sent_count !== 16'd5) begin
            errors++;
            $display("FAIL limit_sent got %0d exp 5", sent_count);
        end
        enable = 1'b0;
        step();
        m_sent = 0;
        checks++;
        if (done !== 1'b0 || sent_count !== 16'd0) begin
            errors++;
            $display("FAIL limit_restart done=%b sent=%0d exp 0/0", done, sent_count);
        end
        enable = 1'b1;
        model_issue(0, 3, f);
        step();
        m_wr = 1'b1;
        checks++;
        if (write !== 1'b1 || data_out !== f) begin
            errors++;
            $display("FAIL limit_resume write=%b data=%h exp 1/%h", write, data_out, f);
        end
        pkt_limit = 16'd0;
    endtask

    task automatic test_round_robin();
        logic [11:0] f;
        int          exp_dst [6] = '{0, 1, 3, 0, 1, 3};
        mode = 2'b01;
        for (int i = 0; i < 6; i++) begin
            model_issue(1, 0, f);
            step();
            checks++;
            if (write !== 1'b1 || data_out !== f || int'(data_out[2:1]) != exp_dst[i]) begin
                errors++;
                $display("FAIL rr cyc %0d write=%b data=%h exp 1/%h dst %0d",
                         i, write, data_out, f, exp_dst[i]);
            end
        end
        mode = 2'b00;
    endtask

    task automatic test_wrap_reset();
        logic [11:0] f;
        do_reset();
        mode = 2'b00; dst_fixed = 2'd1; gap = 8'd0; pkt_limit = 16'd0; enable = 1'b1;
        for (int i = 0; i < 130; i++) begin
            model_issue(0, 1, f);
            step();
            checks++;
            if (write !== 1'b1 || data_out !== f) begin
                errors++;
                $display("FAIL wrap cyc %0d write=%b data=%h exp 1/%h", i, write, data_out, f);
            end
            if (i == 128) begin
                checks++;
                if (data_out[11:5] !== 7'd0) begin
                    errors++;
                    $display("FAIL wrap_seq got %0d exp 0", data_out[11:5]);
                end
            end
        end
        gap = 8'd5;
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (write !== 1'b0 || data_out !== 12'h000 || sent_count !== 16'd0 ||
            stall_count !== 16'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_gap write=%b data=%h sent=%0d stall=%0d done=%b exp all 0",
                     write, data_out, sent_count, stall_count, done);
        end
        reset = 1'b0;
        gap = 8'd0;
        model_reset();
        step();
        checks++;
        if (write !== 1'b1 || data_out !== mk_flit(0, 1)) begin
            errors++;
            $display("FAIL after_reset write=%b data=%h exp 1/%h", write, data_out, mk_flit(0, 1));
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; full = 1'b0; almost_full = 1'b0; enable = 1'b0;
        mode = 2'b00; src_id = 2'(SRC); dst_fixed = 2'd3; gap = 8'd0; pkt_limit = 16'd0;
        model_reset();
        test_reset();
        test_free_run();
        test_back_pressure();
        test_random_traffic();
        test_gap();
        test_limit();
        test_round_robin();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
